// File: rtl/memory_controller.sv
// Word-addressed main memory behind the processor's MAR/MBR port: optional wait states,
// out-of-range flagging and a preload port that only writes while the core is quiet.
module memory_controller #(
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned DEPTH       = 256,
    parameter int unsigned ADDR_W      = 8,
    parameter int unsigned WAIT_STATES = 0,
    parameter int unsigned CNT_W       = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [31:0]       mar,
    input  logic [DATA_W-1:0] mbr_wdata,
    input  logic              mem_enable,
    input  logic              mem_op,
    output logic [DATA_W-1:0] mbr_rdata,
    output logic              mem_ready,
    output logic              mem_busy,
    output logic              addr_err,
    input  logic              load_we,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic [DATA_W-1:0] load_data
);

    localparam int unsigned MAR_W = 32;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP
    } state_t;

    state_t              r_state;
    state_t              w_next_state;
    logic [CNT_W-1:0]    r_cnt;
    logic [CNT_W-1:0]    w_cnt_next;

    logic [MAR_W-1:0]    r_mar;
    logic [DATA_W-1:0]   r_wdata;
    logic                r_op;

    logic [DATA_W-1:0]   r_rdata;
    logic                r_ready;
    logic                r_busy;
    logic                r_err;

    logic [DATA_W-1:0]   r_ram [DEPTH];

    logic                w_accept;
    logic                w_access;
    logic [MAR_W-1:0]    w_acc_mar;
    logic [DATA_W-1:0]   w_acc_wdata;
    logic                w_acc_op;
    logic                w_oor;
    logic [ADDR_W-1:0]   w_idx;
    logic                w_ram_we;
    logic                w_load;

    // A zero-wait access uses the live request; a delayed one uses what was latched on acceptance.
    always_comb begin
        w_accept    = (r_state != S_WAIT) && mem_enable;
        w_access    = ((WAIT_STATES == 0) && w_accept) || ((r_state == S_WAIT) && (r_cnt == '0));
        w_acc_mar   = (r_state == S_WAIT) ? r_mar   : mar;
        w_acc_wdata = (r_state == S_WAIT) ? r_wdata : mbr_wdata;
        w_acc_op    = (r_state == S_WAIT) ? r_op    : mem_op;
        w_oor       = (w_acc_mar >= MAR_W'(DEPTH));
        w_idx       = w_acc_mar[ADDR_W-1:0];
        w_ram_we    = !reset && w_access && w_acc_op && !w_oor;
        w_load      = !reset && load_we && (r_state == S_IDLE) && !mem_enable;
    end

    always_comb begin
        w_next_state = r_state;
        w_cnt_next   = r_cnt;
        case (r_state)
            S_IDLE, S_RESP: begin
                if (mem_enable) begin
                    if (WAIT_STATES == 0) begin
                        w_next_state = S_RESP;
                    end else begin
                        w_next_state = S_WAIT;
                        w_cnt_next   = CNT_W'(WAIT_STATES - 1);
                    end
                end else begin
                    w_next_state = S_IDLE;
                end
            end
            S_WAIT: begin
                if (r_cnt == '0) begin
                    w_next_state = S_RESP;
                end else begin
                    w_cnt_next = r_cnt - CNT_W'(1);
                end
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next_state;
            r_cnt   <= w_cnt_next;
        end
    end

    // Busy covers the WAIT cycles still counting down; the final WAIT cycle (access edge next) reads not-busy.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_mar   <= '0;
            r_wdata <= '0;
            r_op    <= 1'b0;
            r_rdata <= '0;
            r_ready <= 1'b0;
            r_busy  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_ready <= w_access;
            r_err   <= w_access && w_oor;
            r_busy  <= (w_next_state == S_WAIT) && (w_cnt_next != '0);
            if (w_accept) begin
                r_mar   <= mar;
                r_wdata <= mbr_wdata;
                r_op    <= mem_op;
            end
            if (w_access && !w_acc_op) begin
                r_rdata <= w_oor ? '0 : r_ram[w_idx];
            end
        end
    end

    // RAM survives reset; the core write wins over preload, which is already gated to quiet cycles.
    always_ff @(posedge clock) begin
        if (w_ram_we) begin
            r_ram[w_idx] <= w_acc_wdata;
        end else if (w_load) begin
            r_ram[load_addr] <= load_data;
        end
    end

    assign mbr_rdata = r_rdata;
    assign mem_ready = r_ready;
    assign mem_busy  = r_busy;
    assign addr_err  = r_err;

endmodule
